fetch_stage: RTL

- Instruction-fetch stage of the pipelined CPU.
- Owns the PC and drives the instruction-side address of the unified memory; the memory returns the instruction word combinationally in the same cycle.
- Captures PC, PC+4 and the instruction word into the IF/ID pipeline register consumed by decode.
- Handles decode stalls, branch/jump redirects, misaligned redirect targets and halt, and keeps a fetched-instruction counter.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: fetch-stage constants, the RUN/HALTED state encoding
// and the IF/ID bundle field widths (also used by the decode stage).
package fetch_stage_pkg;

   // IF/ID bundle field widths
   localparam int INST_W = 32;
   localparam int PC_W   = 32;

   // Default constants for the fetch stage
   localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

   // Fetch FSM encoding (1 bit)
   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load            capture {inst_in, pc_in, pc4_in} and mark valid
//   flush           invalidate; inst becomes NOP_INST, pc/pc4 are kept
//   inst_in, pc_in, pc4_in   bundle to capture
//   valid, inst, pc, pc4     registered bundle consumed by decode
// flush wins over load; with neither asserted the register holds.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic              flush,
   input  logic [INST_W-1:0] inst_in,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [PC_W-1:0]   pc4_in,
   output logic              valid,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   pc4
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid <= 1'b0;
         inst  <= NOP_INST;
         pc    <= '0;
         pc4   <= '0;
      end else if (flush) begin
         // Bubble: only valid and inst change, addresses stay for debug
         valid <= 1'b0;
         inst  <= NOP_INST;
      end else if (load) begin
         valid <= 1'b1;
         inst  <= inst_in;
         pc    <= pc_in;
         pc4   <= pc4_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   imem_addr/imem_data  instruction-side memory port (combinational read)
//   stall              decode hazard: hold PC and IF/ID
//   redirect/redirect_pc taken branch/jump target
//   halt_req           halting instruction reached commit
//   if_id_*            IF/ID bundle to decode
//   fetch_halted       stage is HALTED
//   fetch_misaligned   sticky: a redirect target had low bits set
//   fetch_count        saturating count of valid IF/ID loads
// Owns the PC, the RUN/HALTED FSM and the fetch counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC  = RESET_PC_DEF,
   parameter logic [INST_W-1:0] NOP_INST  = NOP_INST_DEF,
   parameter int                CNT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic [PC_W-1:0]      imem_addr,
   input  logic [INST_W-1:0]    imem_data,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [PC_W-1:0]      redirect_pc,
   input  logic                 halt_req,
   output logic                 if_id_valid,
   output logic [INST_W-1:0]    if_id_inst,
   output logic [PC_W-1:0]      if_id_pc,
   output logic [PC_W-1:0]      if_id_pc4,
   output logic                 fetch_halted,
   output logic                 fetch_misaligned,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   fetch_state_e         state_reg, state_next;
   logic [PC_W-1:0]      pc_reg, pc_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic                 mis_reg, mis_next;
   logic                 load, flush;
   logic [PC_W-1:0]      pc_plus4;

   assign pc_plus4 = pc_reg + 32'd4;   // wraps naturally mod 2^32

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_RUN;
         pc_reg    <= RESET_PC;
         cnt_reg   <= '0;
         mis_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cnt_reg   <= cnt_next;
         mis_reg   <= mis_next;
      end
   end

   // Priority in RUN: halt (oldest) > redirect > stall > normal fetch
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      cnt_next   = cnt_reg;
      mis_next   = mis_reg;
      load       = 1'b0;
      flush      = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (halt_req) begin
               state_next = ST_HALTED;
               flush      = 1'b1;
            end else if (redirect) begin
               pc_next = redirect_pc & ~32'h3;
               flush   = 1'b1;
               if (redirect_pc[1:0] != 2'b00)
                  mis_next = 1'b1;
            end else if (!stall) begin
               load    = 1'b1;
               pc_next = pc_plus4;
               if (cnt_reg != '1)
                  cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
         end
         ST_HALTED: begin
            // Absorbing; keep the bubble in IF/ID
            flush = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .CLK     (CLK),
      .RST     (RST),
      .load    (load),
      .flush   (flush),
      .inst_in (imem_data),
      .pc_in   (pc_reg),
      .pc4_in  (pc_plus4),
      .valid   (if_id_valid),
      .inst    (if_id_inst),
      .pc      (if_id_pc),
      .pc4     (if_id_pc4)
   );

   assign imem_addr        = pc_reg;
   assign fetch_halted     = (state_reg == ST_HALTED);
   assign fetch_misaligned = mis_reg;
   assign fetch_count      = cnt_reg;

endmodule
